// File: rtl/cover_toggle_collector_if.sv
// Valid/ready stream carrying one global cover index per beat.
// The collector drives the master side. The consumer uses the slave side.
interface cover_toggle_collector_if #(
    parameter int IDX_W = 64
) ();
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky first-hit bitmap, exactly-once index stream,
// run-time clear and a saturating count of distinct covered points.
module cover_toggle_collector #(
    parameter int              WIDTH       = 29,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int              IDX_W       = 64,
    parameter int              CNT_W       = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          valid,
    input  logic                      enable,
    input  logic                      clear,
    cover_toggle_collector_if.master  stream,
    output logic [CNT_W-1:0]          hit_count,
    output logic                      busy
);
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [IDX_W-1:0] BASE    = IDX_W'(COVER_INDEX);
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic [WIDTH-1:0] new_hits;
    logic [PC_W-1:0]  pop_cnt;
    logic [SUM_W-1:0] cnt_sum;
    logic [SEL_W-1:0] sel;
    logic             pend_any;
    logic             out_free;

    assign new_hits = valid & ~seen_q;
    assign pend_any = |pend_q;
    assign out_free = !out_valid_q || stream.out_ready;
    assign cnt_sum  = SUM_W'(hit_count_q) + SUM_W'(pop_cnt);

    // Scanning from the top down leaves the lowest set bit in sel.
    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + PC_W'(new_hits[i]);
        end
    end

    always_comb begin
        seen_d      = seen_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        hit_count_d = hit_count_q;
        if (clear) begin
            // A beat still waiting for its consumer survives. Nothing new is loaded.
            seen_d      = '0;
            pend_d      = '0;
            hit_count_d = '0;
            if (out_free) begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (out_free) begin
                if (pend_any) begin
                    out_valid_d = 1'b1;
                    out_index_d = BASE + IDX_W'(sel);
                    pend_d[sel] = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            if (enable) begin
                seen_d      = seen_q | valid;
                pend_d      = pend_d | new_hits;
                hit_count_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_q      <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            hit_count_q <= '0;
        end else begin
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_index = out_index_q;
    assign hit_count        = hit_count_q;
    assign busy             = pend_any || out_valid_q;
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Scoreboard bench: a 16-bit-count collector and a 2-bit-count collector share the same stimulus.
// Each beat is checked against the set of first-hit indices the bench expects.
module tb_cover_toggle_collector;
    localparam int              WIDTH = 29;
    localparam longint unsigned BASE  = 100;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] valid = '0;
    logic [15:0]      hc;
    logic [1:0]       hc_s;
    logic             busy, busy_s;

    always #5 clock = ~clock;

    cover_toggle_collector_if #(.IDX_W(64)) bus   ();
    cover_toggle_collector_if #(.IDX_W(64)) bus_s ();
    assign bus.out_ready   = ready;
    assign bus_s.out_ready = ready;

    cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(BASE), .IDX_W(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
        .stream(bus), .hit_count(hc), .busy(busy));

    cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(BASE), .IDX_W(64), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
        .stream(bus_s), .hit_count(hc_s), .busy(busy_s));

    int              n_checks = 0;
    int              n_errors = 0;
    longint unsigned exp_q[$];
    longint unsigned exp_s[$];
    longint unsigned got_log[$];
    bit              seen_m[WIDTH];
    int              count_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A beat must match an outstanding first hit. Duplicates and stray indices find none.
    task automatic take(input int which, input logic [63:0] idx);
        int pos;
        pos = -1;
        if (which == 0) begin
            foreach (exp_q[k]) if (pos < 0 && exp_q[k] == idx) pos = k;
            if (pos >= 0) exp_q.delete(pos);
        end else begin
            foreach (exp_s[k]) if (pos < 0 && exp_s[k] == idx) pos = k;
            if (pos >= 0) exp_s.delete(pos);
        end
        n_checks++;
        if (pos < 0) begin
            n_errors++;
            $display("FAIL unexpected_beat dut%0d: got index %0d expected none outstanding", which, idx);
        end else begin
            $display("beat dut%0d index=%0d", which, idx);
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] v, input logic en, input logic clr, input logic rst_n);
        longint unsigned keep;
        valid  = v;
        enable = en;
        clear  = clr;
        reset  = rst_n;
        @(posedge clock);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            exp_s.delete();
            foreach (seen_m[i]) seen_m[i] = 1'b0;
            count_m = 0;
        end else if (clr) begin
            // Only used while the lowest outstanding beat is stalled on the output.
            if (exp_q.size() > 0) begin
                keep = exp_q[0];
                exp_q.delete();
                exp_s.delete();
                exp_q.push_back(keep);
                exp_s.push_back(keep);
            end
            foreach (seen_m[i]) seen_m[i] = 1'b0;
            count_m = 0;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i] && !seen_m[i]) begin
                    seen_m[i] = 1'b1;
                    count_m++;
                    exp_q.push_back(BASE + longint'(i));
                    exp_s.push_back(BASE + longint'(i));
                end
            end
        end
        valid = '0;
        clear = 1'b0;
        reset = 1'b1;
        check("hit_count", 64'(hc), 64'((count_m > 65535) ? 65535 : count_m));
        check("hit_count_sat", 64'(hc_s), 64'((count_m > 3) ? 3 : count_m));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (exp_q.size() == 0 && exp_s.size() == 0) break;
            idle(1);
        end
        idle(1);
        check({name, "_outstanding"}, 64'(exp_q.size() + exp_s.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_busy_sat"}, 64'(busy_s), 64'd0);
    endtask

    // Monitor: consumes beats and checks that a stalled beat holds still.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_idx   = '0;
    always @(negedge clock) begin
        if (reset) begin
            if (prev_stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_index", bus.out_index, prev_idx);
            end
            if (bus.out_valid && ready) begin
                take(0, bus.out_index);
                got_log.push_back(bus.out_index);
            end
            if (bus_s.out_valid && ready) take(1, bus_s.out_index);
            prev_stall = bus.out_valid && !ready;
            prev_idx   = bus.out_index;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v;
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_index", bus.out_index, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Single hit: beat visible two edges after the hit.
        ready = 1'b1;
        step(WIDTH'(1) << 5, 1'b1, 1'b0, 1'b1);
        check("single_not_yet", 64'(bus.out_valid), 64'd0);
        idle(1);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_index", bus.out_index, 64'd105);
        idle(1);
        check("single_done_valid", 64'(bus.out_valid), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // Multi-hit under backpressure.
        ready = 1'b0;
        got_log.delete();
        step((WIDTH'(1) << 20) | (WIDTH'(1) << 3) | (WIDTH'(1) << 7), 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_index", bus.out_index, 64'd103);
        end
        ready = 1'b1;
        idle(4);
        check("bp_beats", 64'(got_log.size()), 64'd3);
        if (got_log.size() == 3) begin
            check("bp_order0", got_log[0], 64'd103);
            check("bp_order1", got_log[1], 64'd107);
            check("bp_order2", got_log[2], 64'd120);
        end
        drain("bp");

        // Dedup of a long toggle, then a hit ignored while disabled.
        for (int k = 0; k < 10; k++) step(WIDTH'(1) << 9, 1'b1, 1'b0, 1'b1);
        idle(5);
        for (int k = 0; k < 3; k++) step(WIDTH'(1) << 9, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(WIDTH'(1) << 10, 1'b0, 1'b0, 1'b1);
        idle(4);
        drain("dedup");

        // Clear while beat +1 is stalled and bit 4 hits in the clear cycle.
        ready = 1'b0;
        step((WIDTH'(1) << 1) | (WIDTH'(1) << 2), 1'b1, 1'b0, 1'b1);
        idle(2);
        step(WIDTH'(1) << 4, 1'b1, 1'b1, 1'b1);
        check("clear_inflight", 64'(bus.out_valid), 64'd1);
        idle(1);
        drain("clear");
        step(WIDTH'(1) << 2, 1'b1, 1'b0, 1'b1);
        drain("clear_rehit");

        // Reset while a beat is stalled and more points are pending.
        ready = 1'b0;
        step((WIDTH'(1) << 5) | (WIDTH'(1) << 6), 1'b1, 1'b0, 1'b1);
        idle(2);
        step('0, 1'b1, 1'b0, 1'b0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_busy_sat", 64'(busy_s), 64'd0);
        ready = 1'b1;
        idle(5);

        // Saturation of the 2-bit counter.
        step(WIDTH'(1) << 0, 1'b1, 1'b0, 1'b1);
        step(WIDTH'(1) << 11, 1'b1, 1'b0, 1'b1);
        step(WIDTH'(1) << 17, 1'b1, 1'b0, 1'b1);
        step(WIDTH'(1) << 22, 1'b1, 1'b0, 1'b1);
        step(WIDTH'(1) << 28, 1'b1, 1'b0, 1'b1);
        drain("sat");

        // Every point at once.
        step('0, 1'b1, 1'b0, 1'b0);
        step('1, 1'b1, 1'b0, 1'b1);
        drain("all");

        // Randomised epochs separated by clears on an idle stream.
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 150; k++) begin
                v     = WIDTH'($urandom & $urandom & $urandom & $urandom);
                ready = ($urandom % 3) != 0;
                step(v, ($urandom % 8) != 0, 1'b0, 1'b1);
            end
            drain("random");
            step('0, 1'b1, 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Parametrised, synthesizable toggle-coverage collector for the formal/fuzz coverage flow. It samples a WIDTH-bit vector of toggle-cover events every cycle and records the first hit of each point in a sticky bitmap. It then serialises each newly covered point, exactly once, as a global cover index over a valid/ready stream. Unlike per-bit simulation-only reporting, it deduplicates hits, tolerates backpressure, supports run-time clearing, and keeps a unique-hit counter.

## Interface

Parameters:
- WIDTH, 29: number of cover points in `valid`; 1..1024.
- COVER_INDEX, 0: global index of bit 0.
- IDX_W, 64: width of `out_index`.
- CNT_W, 16: width of `hit_count`.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- valid  in  WIDTH  per-point cover event for the current cycle.
- enable  in  1  when low, `valid` is ignored; draining of the stream continues.
- clear  in  1  one-cycle pulse that forgets all coverage state.
- out_valid  out  1  a cover index beat is offered.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  IDX_W  COVER_INDEX + bit position (zero-extended).
- hit_count  out  CNT_W  number of distinct points covered since reset/clear; saturating.
- busy  out  1  `pend` is non-zero or `out_valid` is high.

## Operation

- State:
  - `seen[WIDTH]`: sticky bitmap of covered points.
  - `pend[WIDTH]`: points covered but not yet emitted.
  - Output register: `out_valid` and `out_index`.
  - `hit_count`.
- Capture, each edge, when reset is high, enable is high and clear is low:
  - new = valid & ~seen.
  - seen |= valid.
  - pend gets new set (merged with the emit rule below).
  - hit_count += popcount(new), saturating at 2^CNT_W-1.
- Emit:
  - The output register is free when out_valid is 0, or when out_valid && out_ready.
  - When free and pend != 0, select i = the lowest set bit of the registered pend. Load out_index = COVER_INDEX + i, set out_valid = 1, and clear pend[i] in the same edge.
  - When free and pend == 0, out_valid goes to 0.
- Ordering: when several points are pending, they are emitted in ascending bit order. A point hit later but with a lower index may overtake pending higher indices.
- Dedup: each point is emitted at most once per reset/clear epoch, regardless of how many cycles it toggles.
- Clear (reset high, clear high):
  - seen, pend and hit_count go to 0.
  - `valid` in that cycle is discarded.
  - An in-flight beat (out_valid=1) is kept and completes normally. No new beat loads on that edge.
- Reset (reset low at an edge): all state goes to 0, overriding every other input, including mid-handshake.
- enable low: seen, pend and hit_count hold. Emission of already pending points proceeds.

## Timing

- Reset values: out_valid=0, out_index=0, hit_count=0, busy=0, seen=0, pend=0.
- Latency: a hit sampled at edge E sets pend at E. With no backpressure, out_valid/out_index are visible after edge E+1, so the first beat appears 2 edges after the hit.
- Throughput: one beat per cycle while out_ready is held high.
- hit_count reflects hits sampled at edge E immediately after E.
- Handshake:
  - A beat transfers on an edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_index is stable.
  - out_valid never drops without a transfer, except on reset.
  - out_valid does not depend combinationally on out_ready.
- busy is registered-state derived (combinational from pend and out_valid), with no input paths.
- Boundaries:
  - All WIDTH bits hit in one cycle gives hit_count += WIDTH and WIDTH consecutive beats.
  - hit_count saturates and never wraps.
  - Index arithmetic is done in IDX_W bits and wraps modulo 2^IDX_W.

## Test plan

- Single hit, no backpressure: WIDTH=29, COVER_INDEX=100, valid=1<<5 for one cycle, out_ready=1 -> one beat out_index=105 two edges later; hit_count=1; busy returns to 0 after the transfer.
- Multi-hit with backpressure: valid bits {20,3,7} in one cycle, out_ready=0 for 4 cycles then 1 -> out_index held at COVER_INDEX+3 while stalled, then beats +3, +7, +20 on consecutive cycles; hit_count=3.
- Dedup and enable: bit 9 high for 10 cycles, then again later -> exactly one beat for +9. Bit 10 asserted with enable=0 -> no beat and hit_count unchanged.
- Clear mid-stream: bits {1,2} hit; clear asserted while beat +1 is stalled; bit 4 hit in the clear cycle -> beat +1 still delivered, no beat for +2 or +4, hit_count=0. Bit 2 re-hit afterwards -> beat +2, hit_count=1.
- Reset mid-operation: beat stalled and pend non-zero, reset low for one edge -> out_valid=0, hit_count=0, busy=0; previously pending points are never emitted.
- Saturation: CNT_W=2, hit 5 distinct points -> hit_count stops at 3; all 5 beats are still emitted.
